// File: rtl/register_file_module_if.sv
// Write/read/dirty bus of the register file; the register file uses the slave side.
// AW is derived here so the bench and the design agree on the address width.
interface register_file_module_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

   logic             WRITE;
   logic [1:0]       WRITE_OP;
   logic [AW-1:0]    WRITE_ADDR;
   logic [WIDTH-1:0] WRITE_DATA;
   logic             DIRTY_CLEAR;
   logic [AW-1:0]    READ_ADDR_A;
   logic [AW-1:0]    READ_ADDR_B;
   logic [WIDTH-1:0] READ_DATA_A;
   logic [WIDTH-1:0] READ_DATA_B;
   logic [DEPTH-1:0] DIRTY;

   modport master (
      output WRITE, WRITE_OP, WRITE_ADDR, WRITE_DATA, DIRTY_CLEAR,
      output READ_ADDR_A, READ_ADDR_B,
      input  READ_DATA_A, READ_DATA_B, DIRTY
   );

   modport slave (
      input  WRITE, WRITE_OP, WRITE_ADDR, WRITE_DATA, DIRTY_CLEAR,
      input  READ_ADDR_A, READ_ADDR_B,
      output READ_DATA_A, READ_DATA_B, DIRTY
   );
endinterface

// File: rtl/register_file_module.sv
// Two-read/one-write register file with load/set/clear/toggle writes and per-register dirty flags.
// Reads are combinational (optional same-cycle write forwarding); state updates on the falling CLK edge, no backpressure.
module register_file_module #(
   parameter int             WIDTH    = 8,
   parameter int             DEPTH    = 8,
   parameter logic [WIDTH-1:0] INIT   = '0,
   parameter bit             ZERO_REG = 1'b0,
   parameter bit             BYPASS   = 1'b1
) (
   input logic CLK,
   input logic RST,
   register_file_module_if.slave bus
);
   localparam int AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_SET   = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_TOGGLE = 2'b11;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0] dirty_q;
   logic [DEPTH-1:0] dirty_d;

   logic [DEPTH-1:0] wr_sel;
   logic             wr_ok;
   logic [WIDTH-1:0] cur_val;
   logic [WIDTH-1:0] nv;
   logic             byp_ok;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   // One-hot decode; out-of-range addresses and a hardwired zero register never select.
   always_comb begin
      wr_sel  = '0;
      cur_val = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.WRITE_ADDR == AW'(i)) begin
            wr_sel[i] = 1'b1;
            cur_val   = regs_q[i];
         end
      end
      if (ZERO_REG) begin
         wr_sel[0] = 1'b0;
      end
      wr_ok = bus.WRITE && (|wr_sel);
   end

   always_comb begin
      nv = bus.WRITE_DATA;
      case (bus.WRITE_OP)
         OP_LOAD:   nv = bus.WRITE_DATA;
         OP_SET:    nv = cur_val | bus.WRITE_DATA;
         OP_CLEAR:  nv = cur_val & ~bus.WRITE_DATA;
         OP_TOGGLE: nv = cur_val ^ bus.WRITE_DATA;
         default:   nv = bus.WRITE_DATA;
      endcase
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = (wr_ok && wr_sel[i]) ? nv : regs_q[i];
      end
      // A write on the same edge as a clear leaves its own flag set.
      dirty_d = (bus.DIRTY_CLEAR ? '0 : dirty_q) | (wr_ok ? wr_sel : '0);
   end

   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!(ZERO_REG && (i == 0))) begin
            if (bus.READ_ADDR_A == AW'(i)) begin
               rd_a = regs_q[i];
            end
            if (bus.READ_ADDR_B == AW'(i)) begin
               rd_b = regs_q[i];
            end
         end
      end
      // Forwarding is suppressed while reset is asserted: the edge will load INIT, not nv.
      byp_ok = BYPASS && RST && wr_ok;
      if (byp_ok && (bus.READ_ADDR_A == bus.WRITE_ADDR)) begin
         rd_a = nv;
      end
      if (byp_ok && (bus.READ_ADDR_B == bus.WRITE_ADDR)) begin
         rd_b = nv;
      end
   end

   always_ff @(negedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= (ZERO_REG && (i == 0)) ? '0 : INIT;
         end
         dirty_q <= '0;
      end else begin
         regs_q  <= regs_d;
         dirty_q <= dirty_d;
      end
   end

   assign bus.READ_DATA_A = rd_a;
   assign bus.READ_DATA_B = rd_b;
   assign bus.DIRTY       = dirty_q;
endmodule

// File: doc/register_file_module.md
REGISTER_FILE_MODULE -- requirements
Module: register_file_module

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per register (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (>=2; need not be a power of 2).
REQ-003 SHALL have parameter INIT, default '0 (WIDTH bits), reset value loaded into every register.
REQ-004 SHALL have parameter ZERO_REG, default 0; when 1, address 0 is hardwired to zero.
REQ-005 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to the read ports.
REQ-006 SHALL define AW = max(1, $clog2(DEPTH)) as the address width.
REQ-007 CLK  in  1  single clock; all state updates on the falling edge.
REQ-008 RST  in  1  reset, synchronous, active-low.
REQ-009 WRITE  in  1  write enable.
REQ-010 WRITE_OP  in  2  write mode: 00 load, 01 set bits (OR), 10 clear bits (AND-NOT), 11 toggle bits (XOR).
REQ-011 WRITE_ADDR  in  AW  target register.
REQ-012 WRITE_DATA  in  WIDTH  write operand.
REQ-013 DIRTY_CLEAR  in  1  clears all dirty flags.
REQ-014 READ_ADDR_A / READ_ADDR_B  in  AW  read port addresses.
REQ-015 READ_DATA_A / READ_DATA_B  out  WIDTH  read port data.
REQ-016 DIRTY  out  DEPTH  bit i = register i written since last reset or DIRTY_CLEAR.

Function
REQ-017 SHALL compute the next value NV from the current value R[WRITE_ADDR]: load -> WRITE_DATA; set -> R|WRITE_DATA; clear -> R&~WRITE_DATA; toggle -> R^WRITE_DATA.
REQ-018 SHALL store NV into R[WRITE_ADDR] on the falling CLK edge when RST=1, WRITE=1 and the address is writable; all other registers SHALL hold.
REQ-019 SHALL treat an address as not writable when it is >= DEPTH, or when it is 0 with ZERO_REG=1; writes to it are ignored and no DIRTY bit changes.
REQ-020 SHALL make reads combinational with zero-cycle latency: READ_DATA_x = R[READ_ADDR_x].
REQ-021 SHALL return 0 on a read of an address >= DEPTH, or of address 0 with ZERO_REG=1.
REQ-022 SHALL, with BYPASS=1, RST=1, WRITE=1, a writable WRITE_ADDR equal to READ_ADDR_x, drive READ_DATA_x = NV in the same cycle; with BYPASS=0 the port shows the stored value until the edge.
REQ-023 SHALL apply bypass independently per port; both ports may read the same address.
REQ-024 SHALL set DIRTY[WRITE_ADDR] on every accepted write, including writes that leave the value unchanged.
REQ-025 SHALL clear all DIRTY bits on an edge with DIRTY_CLEAR=1; on a simultaneous accepted write, DIRTY[WRITE_ADDR] SHALL end at 1 (write wins).
REQ-026 SHALL keep DIRTY[0] at 0 when ZERO_REG=1, and DIRTY bits for indices >= DEPTH SHALL not exist.

Reset
REQ-027 SHALL, on a falling CLK edge with RST=0, load every register with INIT (address 0 with 0 if ZERO_REG=1) and clear DIRTY to all zeros; WRITE and DIRTY_CLEAR are ignored on that edge.
REQ-028 SHALL suppress bypass while RST=0; read ports show stored values.
REQ-029 SHALL not change state asynchronously; RST deasserted mid-cycle takes effect only at the next falling edge.
REQ-030 SHALL make the reset values READ_DATA_A/B = INIT (or 0 per REQ-021) and DIRTY = 0 after the reset edge.

Verification (WIDTH=8, DEPTH=8 unless stated)
REQ-031 Reset edge, then read all addresses -> every READ_DATA = INIT (test INIT=8'hA5), DIRTY=8'h00.
REQ-032 Load 8'h3C to addr 2, set 8'h81, clear 8'h0C, toggle 8'hFF on consecutive edges -> addr 2 reads 3C, BD, B1, 4E; DIRTY=8'h04.
REQ-033 BYPASS=1: WRITE load 8'h55 to addr 5 with READ_ADDR_A=5 -> READ_DATA_A=55 before the edge; BYPASS=0 -> old value until after the edge.
REQ-034 ZERO_REG=1: load 8'hFF to addr 0 -> READ_DATA=00, DIRTY[0]=0; DEPTH=6: write to addr 7 -> no state change, read of addr 7 = 00.
REQ-035 DIRTY_CLEAR together with a write to addr 3, DIRTY previously 8'h11 -> DIRTY=8'h08.
REQ-036 RST=0 on the same edge as WRITE to addr 1 -> addr 1 = INIT, DIRTY=00; register contents at INIT, bypass not visible during reset.
